// File: rtl/adder_accumulator.sv
// adder_accumulator
//   Streaming signed accumulator. Operands arrive on a valid/ready stream and
//   are added to the running sum through a carry-bypass adder. When a packet
//   closes (in_last, or the beat counter reaches its ceiling), the total, a
//   sticky overflow flag and the beat count are held on a valid/ready output
//   until they are taken.
//
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   in_valid     in   operand present
//   in_ready     out  operand can be accepted (ACCUM state)
//   in_data      in   W-bit signed operand
//   in_last      in   final operand of the packet
//   out_valid    out  result held (DONE state)
//   out_ready    in   consumer takes the result
//   out_sum      out  W-bit signed packet total
//   out_overflow out  set if any beat of the packet overflowed
//   out_count    out  beats accumulated
//
//   carry_bypass_adder
//     a, b   in   W-bit operands
//     cin    in   carry in
//     sum    out  W-bit sum
//     cout   out  carry out
//     overflow out signed overflow of a + b

module carry_bypass_adder #(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int NB = W / N;

   logic w_carry;
   logic w_blk_cin;
   logic w_prop;

   // Ripple inside each N-bit block; if every bit of the block propagates,
   // the block carry-out is taken straight from its carry-in.
   always_comb begin
      sum       = '0;
      w_carry   = cin;
      w_blk_cin = 1'b0;
      w_prop    = 1'b0;
      for (int blk = 0; blk < NB; blk++) begin
         w_blk_cin = w_carry;
         w_prop    = 1'b1;
         for (int i = 0; i < N; i++) begin
            sum[blk*N+i] = a[blk*N+i] ^ b[blk*N+i] ^ w_carry;
            w_carry      = (a[blk*N+i] & b[blk*N+i]) |
                           ((a[blk*N+i] ^ b[blk*N+i]) & w_carry);
            w_prop       = w_prop & (a[blk*N+i] ^ b[blk*N+i]);
         end
         if (w_prop) begin
            w_carry = w_blk_cin;
         end
      end
      cout = w_carry;
   end

   assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// State table
//   state    | meaning
//   ST_ACCUM | accepting operands, in_ready=1
//   ST_DONE  | packet result held, out_valid=1, waiting for out_ready
module adder_accumulator #(
   parameter int W        = 32,
   parameter int N        = 4,
   parameter int CNTW     = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_sum,
   output logic            out_overflow,
   output logic [CNTW-1:0] out_count
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_acc;
   logic            r_ovf;
   logic [CNTW-1:0] r_cnt;

   logic [W-1:0]    w_sum;
   logic            w_cout;
   logic            w_add_ovf;
   logic            w_accept;
   logic            w_drain;
   logic [CNTW-1:0] w_cnt_inc;
   logic            w_cnt_full;
   logic [W-1:0]    w_clamp;
   logic [W-1:0]    w_acc_nxt;

   carry_bypass_adder #(
      .W (W),
      .N (N)
   ) u_adder (
      .a        (r_acc),
      .b        (in_data),
      .cin      (1'b0),
      .sum      (w_sum),
      .cout     (w_cout),
      .overflow (w_add_ovf)
   );

   assign in_ready     = (r_state == ST_ACCUM);
   assign out_valid    = (r_state == ST_DONE);
   assign out_sum      = r_acc;
   assign out_overflow = r_ovf;
   assign out_count    = r_cnt;

   assign w_accept   = in_valid && in_ready;
   assign w_drain    = out_valid && out_ready;
   assign w_cnt_inc  = r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
   assign w_cnt_full = (w_cnt_inc == {CNTW{1'b1}});

   // Overflow direction follows the operand sign: both inputs share it.
   assign w_clamp   = in_data[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   assign w_acc_nxt = (SATURATE && w_add_ovf) ? w_clamp : w_sum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (w_accept && (in_last || w_cnt_full)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (w_drain) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_acc_nxt;
         r_ovf <= r_ovf | w_add_ovf;
         r_cnt <= w_cnt_inc;
      end
   end

endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator
//   Directed bench for adder_accumulator. Three instances: wrap mode,
//   saturate mode, and a 4-bit beat counter for the forced packet end.
//   Inputs in_data/in_last/rst_n are shared; each instance has its own
//   in_valid/out_ready so only the selected one sees traffic.

module tb_adder_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic        or0 = 1'b0, or1 = 1'b0, or2 = 1'b0;

   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic [31:0] sum0, sum1, sum2;
   logic        of0, of1, of2;
   logic [7:0]  cnt0, cnt1;
   logic [3:0]  cnt2;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adder_accumulator #(.W(32), .N(4), .CNTW(8), .SATURATE(1'b0)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_data(in_data),
      .in_last(in_last), .out_valid(ov0), .out_ready(or0), .out_sum(sum0),
      .out_overflow(of0), .out_count(cnt0));

   adder_accumulator #(.W(32), .N(4), .CNTW(8), .SATURATE(1'b1)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_data(in_data),
      .in_last(in_last), .out_valid(ov1), .out_ready(or1), .out_sum(sum1),
      .out_overflow(of1), .out_count(cnt1));

   adder_accumulator #(.W(32), .N(4), .CNTW(4), .SATURATE(1'b0)) u_dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_data(in_data),
      .in_last(in_last), .out_valid(ov2), .out_ready(or2), .out_sum(sum2),
      .out_overflow(of2), .out_count(cnt2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_v(input int sel, input logic val);
      case (sel)
         0: v0 = val;
         1: v1 = val;
         default: v2 = val;
      endcase
   endtask

   task automatic set_or(input int sel, input logic val);
      case (sel)
         0: or0 = val;
         1: or1 = val;
         default: or2 = val;
      endcase
   endtask

   function automatic logic [31:0] g_sum(input int sel);
      case (sel)
         0: return sum0;
         1: return sum1;
         default: return sum2;
      endcase
   endfunction

   function automatic logic [31:0] g_cnt(input int sel);
      case (sel)
         0: return {24'd0, cnt0};
         1: return {24'd0, cnt1};
         default: return {28'd0, cnt2};
      endcase
   endfunction

   function automatic logic g_ovf(input int sel);
      case (sel)
         0: return of0;
         1: return of1;
         default: return of2;
      endcase
   endfunction

   function automatic logic g_ov(input int sel);
      case (sel)
         0: return ov0;
         1: return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic g_ir(input int sel);
      case (sel)
         0: return ir0;
         1: return ir1;
         default: return ir2;
      endcase
   endfunction

   // One beat accepted at the next edge; outputs sampled 1 ns after it.
   task automatic beat(input int sel, input logic [31:0] d, input logic last);
      set_v(sel, 1'b1);
      in_data = d;
      in_last = last;
      @(posedge clk);
      #1;
      set_v(sel, 1'b0);
      in_last = 1'b0;
   endtask

   task automatic result(input string tag, input int sel, input logic [31:0] e_sum,
                         input logic e_ovf, input logic [31:0] e_cnt);
      chk({tag, ".valid"}, {31'd0, g_ov(sel)}, 32'd1);
      chk({tag, ".sum"},   g_sum(sel), e_sum);
      chk({tag, ".ovf"},   {31'd0, g_ovf(sel)}, {31'd0, e_ovf});
      chk({tag, ".count"}, g_cnt(sel), e_cnt);
   endtask

   task automatic drain(input string tag, input int sel);
      set_or(sel, 1'b1);
      @(posedge clk);
      #1;
      set_or(sel, 1'b0);
      chk({tag, ".drain_valid"}, {31'd0, g_ov(sel)}, 32'd0);
      chk({tag, ".drain_ready"}, {31'd0, g_ir(sel)}, 32'd1);
      chk({tag, ".drain_sum"},   g_sum(sel), 32'd0);
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk("rst.valid", {31'd0, g_ov(s)}, 32'd0);
         chk("rst.ready", {31'd0, g_ir(s)}, 32'd1);
         chk("rst.sum",   g_sum(s), 32'd0);
         chk("rst.ovf",   {31'd0, g_ovf(s)}, 32'd0);
         chk("rst.count", g_cnt(s), 32'd0);
      end
      rst_n = 1'b1;

      // 1: 21 + 10
      beat(0, 32'd21, 1'b0);
      chk("t1.mid_valid", {31'd0, ov0}, 32'd0);
      beat(0, 32'd10, 1'b1);
      result("t1", 0, 32'd31, 1'b0, 32'd2);
      chk("t1.in_ready", {31'd0, ir0}, 32'd0);
      drain("t1", 0);

      // 2: -21 + -10
      beat(0, -32'sd21, 1'b0);
      beat(0, -32'sd10, 1'b1);
      result("t2", 0, 32'hFFFF_FFE1, 1'b0, 32'd2);
      drain("t2", 0);

      // 3a: wrap on positive overflow
      beat(0, 32'h4000_0000, 1'b0);
      beat(0, 32'h4000_0000, 1'b1);
      result("t3a", 0, 32'h8000_0000, 1'b1, 32'd2);
      drain("t3a", 0);

      // 3b: clamp positive
      beat(1, 32'h4000_0000, 1'b0);
      beat(1, 32'h4000_0000, 1'b1);
      result("t3b", 1, 32'h7FFF_FFFF, 1'b1, 32'd2);
      drain("t3b", 1);

      // 3c: clamp negative on the third beat
      beat(1, 32'hC000_0000, 1'b0);
      beat(1, 32'hC000_0000, 1'b0);
      chk("t3c.mid_ovf", {31'd0, of1}, 32'd0);
      beat(1, 32'hC000_0000, 1'b1);
      result("t3c", 1, 32'h8000_0000, 1'b1, 32'd3);
      drain("t3c", 1);

      // 4: backpressure, in_valid ignored in DONE
      beat(0, 32'h7FFF_FFFF, 1'b0);
      beat(0, 32'h8000_0001, 1'b1);
      v0 = 1'b1;
      in_data = 32'd5;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         result("t4.hold", 0, 32'd0, 1'b0, 32'd2);
         chk("t4.in_ready", {31'd0, ir0}, 32'd0);
      end
      v0 = 1'b0;
      drain("t4", 0);
      beat(0, 32'd5, 1'b1);
      result("t4.next", 0, 32'd5, 1'b0, 32'd1);
      drain("t4.next", 0);

      // 5: forced end at 15 beats with CNTW=4
      v2 = 1'b1;
      in_data = 32'd1;
      in_last = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("t5.beat14_valid", {31'd0, ov2}, 32'd0);
      @(posedge clk);
      #1;
      result("t5", 2, 32'd15, 1'b0, 32'd15);
      repeat (2) @(posedge clk);
      #1;
      result("t5.hold", 2, 32'd15, 1'b0, 32'd15);
      drain("t5", 2);
      in_last = 1'b1;
      @(posedge clk);
      #1;
      v2 = 1'b0;
      in_last = 1'b0;
      result("t5.beat16", 2, 32'd1, 1'b0, 32'd1);
      drain("t5.beat16", 2);

      // 6: reset mid-packet, valid beat on the reset edge must be dropped
      beat(0, 32'd100, 1'b0);
      beat(0, 32'd200, 1'b0);
      rst_n = 1'b0;
      v0 = 1'b1;
      in_data = 32'd999;
      @(posedge clk);
      #1;
      v0 = 1'b0;
      rst_n = 1'b1;
      chk("t6.rst_sum", sum0, 32'd0);
      chk("t6.rst_count", {24'd0, cnt0}, 32'd0);
      beat(0, 32'd7, 1'b1);
      result("t6", 0, 32'd7, 1'b0, 32'd1);
      // reset while in DONE
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("t6.done_rst_valid", {31'd0, ov0}, 32'd0);
      chk("t6.done_rst_ready", {31'd0, ir0}, 32'd1);
      chk("t6.done_rst_sum",   sum0, 32'd0);
      chk("t6.done_rst_count", {24'd0, cnt0}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
